cpu_clock_controller: RTL and testbench
=======================================

Name: cpu_clock_controller

Overview:
- Sequences the BasicCPU's execution rate: generates a one-cycle clock-enable (cpu_en) from the board clock at a programmable divide ratio.
- Modes: free-run, halt, single-step and N-step burst, for board-level debug.
- Replaces the derived-clock approach: the CPU stays on the board clock and is gated by cpu_en. A toggle output (out_clock) is kept for an LED.

Parameters:
- DIV_WIDTH, 32, width of divide register and tick counter
- DEFAULT_DIV, 12500000, divide value loaded at reset (tick period = DEFAULT_DIV+1 clocks)
- STEP_WIDTH, 16, width of burst length and step counter

Ports:
- clock  in  1  board clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- div_load  in  1  load div_value into divide register this cycle
- div_value  in  DIV_WIDTH  new divide value
- mode  in  2  00 HALT, 01 RUN, 10 STEP, 11 BURST
- step_req  in  1  step/burst trigger (button or host)
- burst_len  in  STEP_WIDTH  steps per burst, sampled at trigger
- cpu_halt_req  in  1  CPU request to stop (HALT instruction)
- cpu_en  out  1  one-cycle enable pulse to CPU
- out_clock  out  1  toggles on every cpu_en
- busy  out  1  high in RUN, STEP_ARM, BURST
- step_count  out  STEP_WIDTH  total cpu_en pulses issued, wraps

Behaviour:
- Reset (async, reset==0): state=HALTED, div_reg=DEFAULT_DIV, count=0, remaining=0. Outputs cpu_en=0, out_clock=0, busy=0, step_count=0.
- Tick generation:
  - count increments only when state is not HALTED.
  - tick=1 in the cycle count==div_reg; count then returns to 0. Period is div_reg+1 clocks; div_reg=0 gives a tick every clock.
  - In HALTED, count is held at 0, so the first tick after leaving HALTED occurs div_reg+1 clocks later (deterministic).
- div_load:
  - div_reg<=div_value and count<=0 next edge, in any state.
  - A tick coincident with div_load is suppressed.
- States:
  - HALTED:
    - mode==RUN goes to RUN.
    - A trigger with mode==STEP goes to STEP_ARM.
    - A trigger with mode==BURST and burst_len!=0 goes to BURST with remaining<=burst_len.
    - A trigger with burst_len==0 is ignored.
  - RUN:
    - Each tick: cpu_en=1 for one clock.
    - mode!=RUN or cpu_halt_req goes to HALTED.
  - STEP_ARM:
    - Next tick: one cpu_en, then HALTED.
  - BURST:
    - Each tick: cpu_en=1 and remaining decrements.
    - The tick that takes remaining 1->0 also returns to HALTED.
  - Triggers outside HALTED are ignored.
- cpu_en is registered: asserted the clock after the internal tick.
- cpu_halt_req:
  - In RUN, STEP_ARM or BURST it forces HALTED at the next edge and cancels remaining.
  - If it coincides with a tick, that tick's cpu_en is suppressed.
  - Ignored in HALTED.
- Mode change mid-STEP_ARM/BURST has no effect; the sequence completes unless cpu_halt_req fires.
- step_count increments on each cpu_en and wraps at 2^STEP_WIDTH-1 to 0.
- busy=1 exactly when state!=HALTED, registered with state.

Optional Feature:
- Macro: CPU_CLOCK_CONTROLLER_STEP_SYNC_EN.
- Defined: step_req passes a 2-flop synchronizer plus rising-edge detect. The trigger is one cycle per press, 3 clocks after the input rises; holding the button gives one trigger.
- Undefined: step_req must come from a synchronous source. Each cycle step_req==1 is a trigger, with no synchronizer and 0 cycles of added latency.

Test Plan:
- Reset release, mode=RUN, div_load=1 with div_value=3 then mode held: cpu_en pulses every 4 clocks; out_clock toggles each pulse; step_count counts 1,2,3...
- mode=STEP, div_value=3, single step_req: exactly one cpu_en; state returns to HALTED; busy high only for 4-5 clocks; a second step_req while busy produces no extra pulse.
- mode=BURST, burst_len=5, div_value=1: exactly 5 cpu_en pulses 2 clocks apart, then busy=0. Repeat with burst_len=0: no pulses, busy stays 0.
- RUN with div_value=0: cpu_en high every clock. Assert cpu_halt_req for 1 clock: cpu_en drops next clock, state HALTED, step_count frozen.
- BURST burst_len=10, assert reset low mid-burst (asynchronously, off clock edge): all outputs 0 immediately; after release, div_reg=DEFAULT_DIV and no pulses in HALTED.
- step_count wrap: preload via RUN with STEP_WIDTH=4 build, 17 pulses leaves step_count=1. With the sync macro defined, a 20-clock step_req high gives one trigger.

Source files
------------

// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller: produces a one-cycle CPU clock-enable (cpu_en) from
// the board clock at a programmable divide ratio. The CPU stays on the board
// clock and is gated by cpu_en.
//
// Modes: HALT, RUN, single STEP and N-step BURST, for board-level debug.
// out_clock toggles on every cpu_en so an LED can show the CPU running.
//
// Optional feature: define CPU_CLOCK_CONTROLLER_STEP_SYNC_EN to pass step_req
// through a 2-flop synchronizer and a rising-edge detector. One press then
// gives one trigger. Without the macro, step_req must come from a synchronous
// source, and every cycle in which it is high is a trigger.
module cpu_clock_controller #(
  parameter int          DIV_WIDTH   = 32,
  parameter int unsigned DEFAULT_DIV = 12500000,
  parameter int          STEP_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  div_load,
  input  logic [DIV_WIDTH-1:0]  div_value,
  input  logic [1:0]            mode,
  input  logic                  step_req,
  input  logic [STEP_WIDTH-1:0] burst_len,
  input  logic                  cpu_halt_req,
  output logic                  cpu_en,
  output logic                  out_clock,
  output logic                  busy,
  output logic [STEP_WIDTH-1:0] step_count,
  output logic [1:0]            state_dbg
);

  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUN      = 2'd1,
    ST_STEP_ARM = 2'd2,
    ST_BURST    = 2'd3
  } state_t;

  state_t                state, state_next;
  logic [DIV_WIDTH-1:0]  div_reg;
  logic [DIV_WIDTH-1:0]  count, count_next;
  logic [STEP_WIDTH-1:0] remaining, remaining_next;
  logic                  tick;
  logic                  en_next;
  logic                  trigger;

  assign state_dbg = state;

`ifdef CPU_CLOCK_CONTROLLER_STEP_SYNC_EN
  logic sync1, sync2, sync_prev;

  // Two-flop synchronizer plus a delayed copy used for the rising-edge detect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= step_req;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign trigger = sync2 & ~sync_prev;
`else
  assign trigger = step_req;
`endif

  // Tick, enable and next-state logic. A tick is suppressed on a div_load
  // cycle, and its enable is suppressed by a coincident cpu_halt_req.
  always_comb begin
    tick           = (state != ST_HALTED) && (count == div_reg) && !div_load;
    en_next        = tick && !cpu_halt_req;
    state_next     = state;
    remaining_next = remaining;

    if (div_load || (state == ST_HALTED) || (count == div_reg)) begin
      count_next = '0;
    end else begin
      count_next = count + DIV_WIDTH'(1);
    end

    case (state)
      ST_HALTED: begin
        if (mode == MODE_RUN) begin
          state_next = ST_RUN;
        end else if (trigger && (mode == MODE_STEP)) begin
          state_next = ST_STEP_ARM;
        end else if (trigger && (mode == MODE_BURST) && (burst_len != '0)) begin
          state_next     = ST_BURST;
          remaining_next = burst_len;
        end
      end
      ST_RUN: begin
        if (cpu_halt_req || (mode != MODE_RUN)) begin
          state_next     = ST_HALTED;
          remaining_next = '0;
        end
      end
      ST_STEP_ARM: begin
        if (cpu_halt_req || tick) begin
          state_next     = ST_HALTED;
          remaining_next = '0;
        end
      end
      ST_BURST: begin
        if (cpu_halt_req) begin
          state_next     = ST_HALTED;
          remaining_next = '0;
        end else if (tick) begin
          remaining_next = remaining - STEP_WIDTH'(1);
          if (remaining == STEP_WIDTH'(1)) begin
            state_next = ST_HALTED;
          end
        end
      end
      default: begin
        state_next     = ST_HALTED;
        remaining_next = '0;
      end
    endcase
  end

  // State, divider, counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_HALTED;
      div_reg    <= DIV_WIDTH'(DEFAULT_DIV);
      count      <= '0;
      remaining  <= '0;
      cpu_en     <= 1'b0;
      out_clock  <= 1'b0;
      busy       <= 1'b0;
      step_count <= '0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      remaining <= remaining_next;
      cpu_en    <= en_next;
      busy      <= (state_next != ST_HALTED);
      if (div_load) begin
        div_reg <= div_value;
      end
      if (en_next) begin
        out_clock  <= ~out_clock;
        step_count <= step_count + STEP_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Bench for cpu_clock_controller. It runs directed scenarios followed by
// random traffic. It compares the DUT each cycle against a reference model
// that counts down the clocks left until the next tick.
module tb_cpu_clock_controller;

  localparam int DIV_WIDTH   = 32;
  localparam int DEFAULT_DIV = 20;
  localparam int STEP_WIDTH  = 4;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  div_load;
  logic [DIV_WIDTH-1:0]  div_value;
  logic [1:0]            mode;
  logic                  step_req;
  logic [STEP_WIDTH-1:0] burst_len;
  logic                  cpu_halt_req;
  logic                  cpu_en;
  logic                  out_clock;
  logic                  busy;
  logic [STEP_WIDTH-1:0] step_count;
  logic [1:0]            state_dbg;

  cpu_clock_controller #(
    .DIV_WIDTH  (DIV_WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV),
    .STEP_WIDTH (STEP_WIDTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .div_load    (div_load),
    .div_value   (div_value),
    .mode        (mode),
    .step_req    (step_req),
    .burst_len   (burst_len),
    .cpu_halt_req(cpu_halt_req),
    .cpu_en      (cpu_en),
    .out_clock   (out_clock),
    .busy        (busy),
    .step_count  (step_count),
    .state_dbg   (state_dbg)
  );

  // Clock: 10 time-unit period.
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int dut_pulses;
  int busy_cycles;

  // Reference model: m_mode is 0 halted, 1 run, 2 step armed, 3 burst.
  // m_left holds the clocks remaining until the next tick.
  int              m_mode;
  longint          m_div;
  longint          m_left;
  int              m_rem;
  bit              m_en, m_oc, m_busy;
  int              m_sc;
  int              m_pulses;
  bit              m_s1, m_s2, m_s3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_div = DEFAULT_DIV; m_left = DEFAULT_DIV; m_rem = 0;
    m_en = 0; m_oc = 0; m_busy = 0; m_sc = 0;
    m_s1 = 0; m_s2 = 0; m_s3 = 0;
  endtask

  // Advance the model by one clock, using the inputs currently driven.
  task automatic model_step();
    bit active, trig, tick, en_n;
    int ns;
    if (!reset) begin
      model_reset();
      return;
    end
`ifdef CPU_CLOCK_CONTROLLER_STEP_SYNC_EN
    trig = m_s2 && !m_s3;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = step_req;
`else
    trig = step_req;
`endif
    active = (m_mode != 0);
    tick   = active && (m_left == 0) && !div_load;
    en_n   = tick && !cpu_halt_req;
    ns     = m_mode;
    case (m_mode)
      0: begin
        if (mode == 2'd1) ns = 1;
        else if (trig && mode == 2'd2) ns = 2;
        else if (trig && mode == 2'd3 && burst_len != 0) begin
          ns = 3; m_rem = int'(burst_len);
        end
      end
      1: if (cpu_halt_req || mode != 2'd1) begin ns = 0; m_rem = 0; end
      2: if (cpu_halt_req || tick) begin ns = 0; m_rem = 0; end
      default: begin
        if (cpu_halt_req) begin ns = 0; m_rem = 0; end
        else if (tick) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) ns = 0;
        end
      end
    endcase
    if (div_load) begin
      m_div  = longint'(div_value);
      m_left = m_div;
    end else if (!active || m_left == 0) begin
      m_left = m_div;
    end else begin
      m_left = m_left - 1;
    end
    m_mode = ns;
    m_en   = en_n;
    m_busy = (ns != 0);
    if (en_n) begin
      m_oc = !m_oc;
      m_sc = (m_sc + 1) % (1 << STEP_WIDTH);
      m_pulses++;
    end
  endtask

  task automatic run_cycle();
    model_step();
    @(posedge clock);
    #1;
    check("cpu_en", 32'(cpu_en), 32'(m_en));
    check("out_clock", 32'(out_clock), 32'(m_oc));
    check("busy", 32'(busy), 32'(m_busy));
    check("step_count", 32'(step_count), 32'(m_sc));
    dut_pulses  += int'(cpu_en);
    busy_cycles += int'(busy);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic phase_start();
    dut_pulses = 0; m_pulses = 0; busy_cycles = 0;
  endtask

  task automatic idle_inputs();
    div_load = 0; div_value = '0; step_req = 0; burst_len = '0; cpu_halt_req = 0;
  endtask

  task automatic load_div(input int v);
    div_load = 1; div_value = 32'(v);
    run_cycle();
    div_load = 0;
  endtask

  task automatic pulse_step();
    step_req = 1;
    run_cycle();
    step_req = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    #1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1;
  endtask

  initial begin
    int budget;
    idle_inputs();
    mode  = 2'd0;
    reset = 0;
    model_reset();
    #2;
    check("rst_cpu_en", 32'(cpu_en), 0);
    check("rst_out_clock", 32'(out_clock), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_step_count", 32'(step_count), 0);
    @(posedge clock);
    #1;
    reset = 1;

    // RUN at divide 3: pulses every 4 clocks.
    phase_start();
    mode = 2'd1;
    load_div(3);
    run_cycles(24);
    check("run_div3_pulses", 32'(dut_pulses), 32'(m_pulses));
    check("run_div3_count", 32'(dut_pulses), 6);

    // Single step at divide 3, with a second request while busy.
    mode = 2'd0;
    run_cycles(3);
    load_div(3);
    phase_start();
    mode = 2'd2;
    pulse_step();
    run_cycles(2);
    pulse_step();
    run_cycles(10);
    check("step_pulses", 32'(dut_pulses), 1);
    check("step_busy_len", 32'(busy_cycles >= 4 && busy_cycles <= 5), 1);

    // Burst of 5 at divide 1, then a burst of length 0.
    mode = 2'd0;
    load_div(1);
    phase_start();
    mode = 2'd3; burst_len = 4'd5;
    pulse_step();
    run_cycles(20);
    check("burst5_pulses", 32'(dut_pulses), 5);
    check("burst5_busy_end", 32'(busy), 0);
    phase_start();
    burst_len = 4'd0;
    pulse_step();
    run_cycles(10);
    check("burst0_pulses", 32'(dut_pulses), 0);
    check("burst0_busy", 32'(busy_cycles), 0);

    // RUN at divide 0, then a single-clock halt request.
    phase_start();
    mode = 2'd1;
    load_div(0);
    run_cycles(8);
    cpu_halt_req = 1;
    mode = 2'd0;
    run_cycle();
    cpu_halt_req = 0;
    run_cycles(6);
    check("halt_pulses", 32'(dut_pulses), 32'(m_pulses));

    // Burst of 10 interrupted by an asynchronous reset between clock edges.
    load_div(2);
    mode = 2'd3; burst_len = 4'd10;
    pulse_step();
    run_cycles(7);
    #3;
    reset = 0;
    #1;
    model_reset();
    check("arst_cpu_en", 32'(cpu_en), 0);
    check("arst_out_clock", 32'(out_clock), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_step_count", 32'(step_count), 0);
    run_cycles(2);
    reset = 1;
    phase_start();
    run_cycles(30);
    check("post_rst_halted_pulses", 32'(dut_pulses), 0);
    mode = 2'd1;
    run_cycles(DEFAULT_DIV + 5);
    check("post_rst_default_div", 32'(dut_pulses), 1);

    // step_count wrap: 17 pulses from zero leave 1 in a 4-bit counter.
    mode = 2'd0;
    idle_inputs();
    do_reset();
    phase_start();
    mode = 2'd1;
    load_div(0);
    budget = 0;
    while (dut_pulses < 17 && budget < 100) begin
      run_cycle();
      budget++;
    end
    check("wrap_budget", 32'(dut_pulses), 17);
    check("wrap_step_count", 32'(step_count), 1);

    // Random traffic.
    phase_start();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      step_req     = ($urandom_range(0, 3) == 0);
      burst_len    = 4'($urandom_range(0, 6));
      cpu_halt_req = ($urandom_range(0, 39) == 0);
      div_load     = ($urandom_range(0, 29) == 0);
      div_value    = 32'($urandom_range(0, 4));
      run_cycle();
    end
    check("random_pulses", 32'(dut_pulses), 32'(m_pulses));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
